// File: rtl/oser4_stream_ctrl.sv
// OSER4 4:1 lane sequencer: PCLK/RESET generation, word FIFO and
// nibble slicer driving D0..D3 and TX0/TX1 on the FCLK domain.
module oser4_stream_ctrl #(
  parameter int         DATA_W     = 8,
  parameter int         FIFO_DEPTH = 4,
  parameter int         RST_CYCLES = 4,
  parameter logic [3:0] IDLE_PAT   = 4'b0000,
  parameter bit         IDLE_TRI   = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [DATA_W-1:0] s_data_i,
  output logic              oser_reset_o,
  output logic              pclk_o,
  output logic [3:0]        d_o,
  output logic [1:0]        tx_o,
  output logic              busy_o,
  output logic              underrun_o
);

  localparam int NW = DATA_W / 4;
  localparam int IW = (NW > 1) ? $clog2(NW) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int TW = $clog2(RST_CYCLES + 4);
  localparam logic [1:0] TX_IDLE = IDLE_TRI ? 2'b11 : 2'b00;

  typedef enum logic [1:0] {
    HOLD,
    WARM,
    RUN
  } state_t;

  state_t            state;
  logic [TW-1:0]     tcnt;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [CW-1:0]     count;
  logic [DATA_W-1:0] cur;
  logic [IW-1:0]     idx;
  logic              have;
  logic              shown;

  logic       full;
  logic       empty;
  logic       push;
  logic       pop;
  logic       run;
  logic       load;
  logic       last;
  logic [3:0] nib;

  assign full      = (count == CW'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign s_ready_o = !full && (state != HOLD);
  assign push      = s_valid_i && s_ready_o;
  assign run       = (state == RUN);
  assign load      = run && !pclk_o;
  assign last      = (idx == IW'(NW - 1));
  assign nib       = cur[{idx, 2'b00} +: 4];
  assign busy_o    = !empty || have || shown;

  // Refill on the mid-slot edge when idle; chain on the last nibble
  assign pop = !empty &&
               ((load && have && last) ||
                (run && pclk_o && !have));

  always_ff @(posedge clk_i) begin
    if (push) mem[wptr] <= s_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= HOLD;
      tcnt         <= '0;
      oser_reset_o <= 1'b1;
      pclk_o       <= 1'b0;
      d_o          <= IDLE_PAT;
      tx_o         <= TX_IDLE;
      underrun_o   <= 1'b0;
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      cur          <= '0;
      idx          <= '0;
      have         <= 1'b0;
      shown        <= 1'b0;
    end else begin
      underrun_o <= 1'b0;
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);

      unique case (state)
        HOLD: begin
          if (tcnt == TW'(RST_CYCLES - 1)) begin
            state        <= WARM;
            tcnt         <= '0;
            oser_reset_o <= 1'b0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        WARM: begin
          pclk_o <= ~pclk_o;
          if (tcnt == TW'(3)) begin
            state <= RUN;
            tcnt  <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        RUN: begin
          pclk_o <= ~pclk_o;
        end
        default: begin
          state <= HOLD;
        end
      endcase

      if (load) begin
        if (have) begin
          d_o   <= nib;
          tx_o  <= 2'b00;
          shown <= 1'b1;
          if (last) have <= 1'b0;
          else      idx  <= idx + 1'b1;
        end else begin
          d_o        <= IDLE_PAT;
          tx_o       <= TX_IDLE;
          shown      <= 1'b0;
          underrun_o <= shown;
        end
      end

      if (pop) begin
        cur  <= mem[rptr];
        idx  <= '0;
        have <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_oser4_stream_ctrl.sv
// Directed bench for oser4_stream_ctrl: start-up, slicing,
// back-to-back streaming, mid-word reset, 16-bit words, driven idle.
module tb_oser4_stream_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic       oser_reset;
  logic       pclk;
  logic [3:0] d;
  logic [1:0] tx;
  logic       busy;
  logic       underrun;

  logic        v16;
  logic [15:0] dat16;
  logic        r16;
  logic        or16;
  logic        p16;
  logic [3:0]  d16;
  logic [1:0]  tx16;
  logic        b16;
  logic        u16r;

  logic       rt;
  logic       ort;
  logic       pt;
  logic [3:0] dt;
  logic [1:0] txt;
  logic       bt;
  logic       ut_under;
  bit         ut_seen = 1'b0;

  int checks = 0;
  int errors = 0;

  oser4_stream_ctrl dut (
    .clk_i(clk), .rst_i(rst),
    .s_valid_i(s_valid), .s_ready_o(s_ready),
    .s_data_i(s_data), .oser_reset_o(oser_reset),
    .pclk_o(pclk), .d_o(d), .tx_o(tx),
    .busy_o(busy), .underrun_o(underrun)
  );

  oser4_stream_ctrl #(.DATA_W(16)) u16 (
    .clk_i(clk), .rst_i(rst),
    .s_valid_i(v16), .s_ready_o(r16),
    .s_data_i(dat16), .oser_reset_o(or16),
    .pclk_o(p16), .d_o(d16), .tx_o(tx16),
    .busy_o(b16), .underrun_o(u16r)
  );

  oser4_stream_ctrl #(
    .IDLE_TRI(1'b0), .IDLE_PAT(4'b0101)
  ) ut (
    .clk_i(clk), .rst_i(rst),
    .s_valid_i(1'b0), .s_ready_o(rt),
    .s_data_i(8'h00), .oser_reset_o(ort),
    .pclk_o(pt), .d_o(dt), .tx_o(txt),
    .busy_o(bt), .underrun_o(ut_under)
  );

  always @(posedge clk) if (ut_under) ut_seen <= 1'b1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] words [5];
  logic [3:0] exp3 [10];
  logic [3:0] exp16 [4];

  initial begin
    int widx;
    int ncol;
    int upcnt;
    bit acc;
    bit saw_full;
    bit done;

    words = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89};
    exp3  = '{4'h1, 4'h0, 4'h3, 4'h2, 4'h5,
              4'h4, 4'h7, 4'h6, 4'h9, 4'h8};
    exp16 = '{4'h4, 4'h3, 4'h2, 4'h1};

    rst = 1'b1;
    s_valid = 1'b0;
    s_data = '0;
    v16 = 1'b0;
    dat16 = '0;
    step();
    step();

    chk("rst_oser", oser_reset, 1);
    chk("rst_pclk", pclk, 0);
    chk("rst_d", d, 4'h0);
    chk("rst_tx", tx, 2'b11);
    chk("rst_ready", s_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_under", underrun, 0);
    chk("t6_rst_tx", txt, 2'b00);
    chk("t6_rst_d", dt, 4'h5);

    // T1: HOLD then WARM
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t1_hold_oser", oser_reset, 1);
      chk("t1_hold_ready", s_ready, 0);
      chk("t1_hold_pclk", pclk, 0);
    end
    step();
    chk("t1_warm_oser", oser_reset, 0);
    chk("t1_warm_pclk0", pclk, 0);
    chk("t1_warm_ready", s_ready, 1);

    // T3: words offered from WARM onward, held valid
    s_valid = 1'b1;
    s_data = words[0];
    widx = 0;
    ncol = 0;
    upcnt = 0;
    saw_full = 1'b0;
    done = 1'b0;
    for (int k = 1; k <= 100 && !done; k++) begin
      acc = s_valid && s_ready;
      step();
      if (acc) begin
        widx++;
        if (widx < 5) s_data = words[widx];
        else s_valid = 1'b0;
      end
      if (!s_ready) saw_full = 1'b1;
      if (k <= 4) begin
        chk("t1_warm_pclk", pclk, k % 2);
        chk("t1_warm_tx", tx, 2'b11);
        chk("t1_warm_oser0", oser_reset, 0);
      end
      if (underrun) begin
        upcnt++;
        chk("t3_under_at_end", ncol, 10);
      end
      if (k > 4 && pclk) begin
        if (tx == 2'b00) begin
          if (ncol < 10) chk("t3_nib", d, exp3[ncol]);
          else chk("t3_extra_nib", tx, 2'b11);
          ncol++;
        end else if (ncol > 0) begin
          chk("t3_no_gap", ncol, 10);
          done = 1'b1;
        end
      end
    end
    chk("t3_done", done, 1);
    chk("t3_ncol", ncol, 10);
    chk("t3_saw_full", saw_full, 1);
    chk("t3_under_cnt", upcnt, 1);
    chk("t3_all_taken", widx, 5);
    chk("t3_idle_tx", tx, 2'b11);
    chk("t3_idle_busy", busy, 0);

    if (pclk) step();
    chk("t3_under_1cyc", underrun, 0);

    // T2: single word 8'hA5
    s_valid = 1'b1;
    s_data = 8'hA5;
    step();
    s_valid = 1'b0;
    chk("t2_e1_tx", tx, 2'b11);
    chk("t2_e1_busy", busy, 1);
    step();
    chk("t2_e2_tx", tx, 2'b11);
    step();
    chk("t2_n0_d", d, 4'h5);
    chk("t2_n0_tx", tx, 2'b00);
    chk("t2_n0_pclk", pclk, 1);
    step();
    chk("t2_n0_hold", d, 4'h5);
    step();
    chk("t2_n1_d", d, 4'hA);
    chk("t2_n1_tx", tx, 2'b00);
    step();
    chk("t2_n1_hold", d, 4'hA);
    chk("t2_n1_busy", busy, 1);
    step();
    chk("t2_idle_d", d, 4'h0);
    chk("t2_idle_tx", tx, 2'b11);
    chk("t2_under", underrun, 1);
    chk("t2_busy0", busy, 0);
    step();
    chk("t2_under_end", underrun, 0);

    // T4: reset while nibble 1 of 8'hC3 is on the pins
    s_valid = 1'b1;
    s_data = 8'hC3;
    step();
    s_data = 8'h11;
    step();
    s_data = 8'h22;
    step();
    chk("t4_n0", d, 4'h3);
    s_data = 8'h33;
    step();
    s_valid = 1'b0;
    step();
    chk("t4_n1", d, 4'hC);
    chk("t4_busy", busy, 1);
    rst = 1'b1;
    step();
    chk("t4_oser", oser_reset, 1);
    chk("t4_pclk", pclk, 0);
    chk("t4_d", d, 4'h0);
    chk("t4_tx", tx, 2'b11);
    chk("t4_busy0", busy, 0);
    chk("t4_ready", s_ready, 0);
    chk("t4_under", underrun, 0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("t4_stale_tx", tx, 2'b11);
      chk("t4_stale_under", underrun, 0);
    end
    chk("t4_busy_end", busy, 0);

    // T5: 16-bit word
    if (p16) step();
    v16 = 1'b1;
    dat16 = 16'h1234;
    step();
    v16 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      step();
      chk("t5_nib", d16, exp16[k]);
      chk("t5_tx", tx16, 2'b00);
    end
    step();
    chk("t5_hold", d16, 4'h1);
    step();
    chk("t5_idle_tx", tx16, 2'b11);
    chk("t5_under", u16r, 1);

    // T6: driven idle pattern instance
    chk("t6_tx", txt, 2'b00);
    chk("t6_d", dt, 4'h5);
    chk("t6_busy", bt, 0);
    chk("t6_no_under", ut_seen, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
